// File: rtl/corereset_pf_pkg.sv
// Shared constants for the fabric reset conditioner: release-synchronizer depth and its legal range.
package corereset_pf_pkg;

   localparam int unsigned SYNC_STAGES_DEF = 3;
   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 8;

endpackage : corereset_pf_pkg

// File: rtl/reset_syn_corereset_pf_if.sv
// Control bundle between the reset conditioner top and its release synchronizer.
interface reset_syn_corereset_pf_if;

   logic clr_n;   // asynchronous clear of every synchronizer stage
   logic en;      // shift enable (release permitted this edge)
   logic rel_n;   // last synchronizer stage, the conditioned reset

   modport master (output clr_n, output en, input rel_n);
   modport slave  (input clr_n, input en, output rel_n);

endinterface : reset_syn_corereset_pf_if

// File: rtl/corereset_pf_sync.sv
// Release synchronizer: async clear, enable-gated shift of ones, STAGES deep.
module corereset_pf_sync
   import corereset_pf_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
   input  logic                      clk,
   reset_syn_corereset_pf_if.slave   sif
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift a one in only when release is allowed; otherwise hold.
   always_comb begin
      sync_d = sync_q;
      if (sif.en) begin
         sync_d = {sync_q[STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge sif.clr_n) begin
      if (!sif.clr_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sif.rel_n = sync_q[STAGES-1];

endmodule : corereset_pf_sync

// File: rtl/reset_syn_corereset_pf.sv
// Fabric reset conditioner: async assert, synchronized and service-gated release.
// Optional feature: define CORERESET_PF_PLL_LOCK_EN to let PLL_LOCK hold the fabric in reset.
module reset_syn_corereset_pf
   import corereset_pf_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic CLK,
   input  logic EXT_RST_N,
   input  logic PLL_LOCK,
   input  logic BANK_x_VDDI_STATUS,
   input  logic BANK_y_VDDI_STATUS,
   input  logic FPGA_POR_N,
   input  logic SS_BUSY,
   input  logic INIT_DONE,
   input  logic FF_US_RESTORE,
   output logic FABRIC_RESET_N,
   output logic PLL_POWERDOWN_B
);

   logic supply_ok_c;
   logic pll_ok_c;
   logic rst_n_c;
   logic release_ok_c;

   assign supply_ok_c = FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS;

`ifdef CORERESET_PF_PLL_LOCK_EN
   assign pll_ok_c = PLL_LOCK;
`else
   // Lock is ignored in this build; the port stays for pin compatibility.
   logic unused_pll_lock;
   assign unused_pll_lock = PLL_LOCK;
   assign pll_ok_c        = 1'b1;
`endif

   assign rst_n_c      = EXT_RST_N & pll_ok_c & INIT_DONE & supply_ok_c;
   assign release_ok_c = ~SS_BUSY & ~FF_US_RESTORE;

   reset_syn_corereset_pf_if u_sync_if ();

   assign u_sync_if.clr_n = rst_n_c;
   assign u_sync_if.en    = release_ok_c;

   corereset_pf_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (CLK),
      .sif (u_sync_if.slave)
   );

   // Straight from the last flop so deassertion cannot glitch.
   assign FABRIC_RESET_N  = u_sync_if.rel_n;
   assign PLL_POWERDOWN_B = supply_ok_c;

endmodule : reset_syn_corereset_pf

// File: tb/tb_reset_syn_corereset_pf.sv
// Directed bench for reset_syn_corereset_pf with an edge-counting reference model.
module tb_reset_syn_corereset_pf;

   localparam int unsigned N = 3;

`ifdef CORERESET_PF_PLL_LOCK_EN
   localparam bit PLL_USED = 1'b1;
`else
   localparam bit PLL_USED = 1'b0;
`endif

   logic CLK = 1'b0;
   logic EXT_RST_N, PLL_LOCK, BANK_x_VDDI_STATUS, BANK_y_VDDI_STATUS;
   logic FPGA_POR_N, SS_BUSY, INIT_DONE, FF_US_RESTORE;
   logic FABRIC_RESET_N, PLL_POWERDOWN_B;

   int  vectors     = 0;
   int  miscompares = 0;
   bit  model_on    = 1'b0;
   int  cnt         = 0;
   logic model_rst_n;

   reset_syn_corereset_pf #(.SYNC_STAGES(N)) dut (
      .CLK                (CLK),
      .EXT_RST_N          (EXT_RST_N),
      .PLL_LOCK           (PLL_LOCK),
      .BANK_x_VDDI_STATUS (BANK_x_VDDI_STATUS),
      .BANK_y_VDDI_STATUS (BANK_y_VDDI_STATUS),
      .FPGA_POR_N         (FPGA_POR_N),
      .SS_BUSY            (SS_BUSY),
      .INIT_DONE          (INIT_DONE),
      .FF_US_RESTORE      (FF_US_RESTORE),
      .FABRIC_RESET_N     (FABRIC_RESET_N),
      .PLL_POWERDOWN_B    (PLL_POWERDOWN_B)
   );

   // 10 MHz
   always #50 CLK = ~CLK;

   // Model: count qualifying edges since reset last went low; released after N of them.
   assign model_rst_n = EXT_RST_N & (PLL_USED ? PLL_LOCK : 1'b1) & INIT_DONE &
                        FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS;

   always @(negedge model_rst_n) cnt = 0;

   always @(posedge CLK) begin
      if (model_rst_n !== 1'b1) cnt = 0;
      else if (!SS_BUSY && !FF_US_RESTORE && cnt < int'(N)) cnt = cnt + 1;
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (model_on) begin
         chk("model_frn", FABRIC_RESET_N, (cnt >= int'(N)) ? 1'b1 : 1'b0);
         chk("model_ppb", PLL_POWERDOWN_B,
             FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Three release edges: low, low, high.
   task automatic release3(input string nm);
      tick(); chk({nm, "_e1"}, FABRIC_RESET_N, 1'b0);
      tick(); chk({nm, "_e2"}, FABRIC_RESET_N, 1'b0);
      tick(); chk({nm, "_e3"}, FABRIC_RESET_N, 1'b1);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: bench did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      EXT_RST_N = 1'b0; PLL_LOCK = 1'b1; BANK_x_VDDI_STATUS = 1'b1;
      BANK_y_VDDI_STATUS = 1'b1; FPGA_POR_N = 1'b1; INIT_DONE = 1'b1;
      SS_BUSY = 1'b1; FF_US_RESTORE = 1'b1;
      #1;
      chk("reset_frn", FABRIC_RESET_N, 1'b0);
      chk("reset_ppb", PLL_POWERDOWN_B, 1'b1);
      model_on = 1'b1;

      // External reset release
      FF_US_RESTORE = 1'b0; SS_BUSY = 1'b0;
      #1 chk("ext_idle", FABRIC_RESET_N, 1'b0);
      EXT_RST_N = 1'b1;
      release3("ext_rel");
      tick(); chk("ext_hold", FABRIC_RESET_N, 1'b1);

      // PLL lock loss
      #10 PLL_LOCK = 1'b0;
      #1 chk("pll_lo", FABRIC_RESET_N, PLL_USED ? 1'b0 : 1'b1);
      PLL_LOCK = 1'b1;
      tick(); chk("pll_e1", FABRIC_RESET_N, PLL_USED ? 1'b0 : 1'b1);
      tick(); chk("pll_e2", FABRIC_RESET_N, PLL_USED ? 1'b0 : 1'b1);
      tick(); chk("pll_e3", FABRIC_RESET_N, 1'b1);

      // Init done
      #10 INIT_DONE = 1'b0;
      #1 chk("init_lo", FABRIC_RESET_N, 1'b0);
      INIT_DONE = 1'b1;
      release3("init_rel");

      // Busy stalls release but never reasserts
      #10 EXT_RST_N = 1'b0; SS_BUSY = 1'b1;
      #1 chk("busy_rst", FABRIC_RESET_N, 1'b0);
      EXT_RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(); chk("busy_stall", FABRIC_RESET_N, 1'b0);
      end
      SS_BUSY = 1'b0;
      release3("busy_rel");
      SS_BUSY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); chk("busy_after", FABRIC_RESET_N, 1'b1);
      end
      FF_US_RESTORE = 1'b1;
      tick(); chk("ffr_after", FABRIC_RESET_N, 1'b1);
      SS_BUSY = 1'b0; FF_US_RESTORE = 1'b0;
      tick(); chk("svc_clear", FABRIC_RESET_N, 1'b1);

      // PLL power-down from supplies, no clock needed
      #10 BANK_y_VDDI_STATUS = 1'b0; FPGA_POR_N = 1'b0;
      #1 chk("ppb_y0_p0", PLL_POWERDOWN_B, 1'b0);
      chk("ppb_frn", FABRIC_RESET_N, 1'b0);
      BANK_y_VDDI_STATUS = 1'b1;
      #1 chk("ppb_y1_p0", PLL_POWERDOWN_B, 1'b0);
      FPGA_POR_N = 1'b1;
      #1 chk("ppb_y1_p1", PLL_POWERDOWN_B, 1'b1);
      BANK_y_VDDI_STATUS = 1'b0;
      #1 chk("ppb_y0_p1", PLL_POWERDOWN_B, 1'b0);
      BANK_y_VDDI_STATUS = 1'b1;
      #1 chk("ppb_all1", PLL_POWERDOWN_B, 1'b1);
      BANK_x_VDDI_STATUS = 1'b0;
      #1 chk("ppb_x0", PLL_POWERDOWN_B, 1'b0);
      BANK_x_VDDI_STATUS = 1'b1;
      release3("supply_rel");

      // Reset pulse mid-release restarts the count
      #10 EXT_RST_N = 1'b0;
      #1 chk("mid_rst", FABRIC_RESET_N, 1'b0);
      EXT_RST_N = 1'b1;
      tick(); chk("mid_e1", FABRIC_RESET_N, 1'b0);
      tick(); chk("mid_e2", FABRIC_RESET_N, 1'b0);
      #10 EXT_RST_N = 1'b0;
      #10 chk("mid_pulse", FABRIC_RESET_N, 1'b0);
      EXT_RST_N = 1'b1;
      release3("mid_rel");

      tick(); tick();
      model_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_reset_syn_corereset_pf

// File: doc/reset_syn_corereset_pf.md
RESET_SYN_CORERESET_PF -- requirements
Module: reset_syn_corereset_pf

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, number of release-synchronizer flops (legal range 2..8).
REQ-002 SHALL have port CLK  input  1  single system clock; all sequential logic on its rising edge.
REQ-003 SHALL have port EXT_RST_N  input  1  external reset, asynchronous, active-low.
REQ-004 SHALL have port PLL_LOCK  input  1  PLL lock indicator, 1 = locked.
REQ-005 SHALL have port BANK_x_VDDI_STATUS  input  1  I/O bank x supply good, 1 = good.
REQ-006 SHALL have port BANK_y_VDDI_STATUS  input  1  I/O bank y supply good, 1 = good.
REQ-007 SHALL have port FPGA_POR_N  input  1  device power-on reset, active-low.
REQ-008 SHALL have port SS_BUSY  input  1  system-services busy, 1 = busy.
REQ-009 SHALL have port INIT_DONE  input  1  device initialization complete, 1 = done.
REQ-010 SHALL have port FF_US_RESTORE  input  1  flash-freeze exit restore in progress, 1 = restoring.
REQ-011 SHALL have port FABRIC_RESET_N  output  1  fabric reset, active-low.
REQ-012 SHALL have port PLL_POWERDOWN_B  output  1  PLL power-down control, active-low.

Function
REQ-013 SHALL form internal async reset rst_n = EXT_RST_N & PLL_LOCK & INIT_DONE & FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS.
REQ-014 SHALL drive FABRIC_RESET_N low asynchronously (no clock edge needed) whenever rst_n = 0.
REQ-015 SHALL clear all SYNC_STAGES synchronizer flops asynchronously while rst_n = 0.
REQ-016 SHALL define release_ok = ~SS_BUSY & ~FF_US_RESTORE, sampled on CLK.
REQ-017 SHALL shift a 1 into the synchronizer on each rising CLK edge where rst_n = 1 and release_ok = 1; when release_ok = 0, synchronizer holds its value.
REQ-018 SHALL drive FABRIC_RESET_N from the last synchronizer stage; rises on the SYNC_STAGES-th qualifying edge (3 edges at default).
REQ-019 SHALL NOT reassert FABRIC_RESET_N due to SS_BUSY or FF_US_RESTORE once released; these only stall release.
REQ-020 SHALL restart the full release sequence from zero if rst_n falls mid-release.
REQ-021 SHALL compute PLL_POWERDOWN_B = FPGA_POR_N & BANK_x_VDDI_STATUS & BANK_y_VDDI_STATUS, purely combinational, independent of CLK.
REQ-022 SHALL be glitch-free on FABRIC_RESET_N deassertion (driven directly by a flop).

Reset
REQ-023 SHALL hold FABRIC_RESET_N = 0 and all synchronizer flops = 0 during reset; PLL_POWERDOWN_B follows REQ-021 at all times.
REQ-024 SHALL use no synchronous reset and no initial values beyond REQ-015.

Configuration
REQ-025 With macro CORERESET_PF_PLL_LOCK_EN defined, PLL_LOCK SHALL participate in rst_n per REQ-013.
REQ-026 Without CORERESET_PF_PLL_LOCK_EN, PLL_LOCK SHALL be ignored (treated as 1); port still present.

Structure
REQ-027 SHALL place SYNC_STAGES default and legal min/max constants in shared package corereset_pf_pkg.
REQ-028 SHALL implement the release synchronizer as sub-module corereset_pf_sync (async clear, enable, SYNC_STAGES deep).

Verification (all inputs 1 except SS_BUSY/FF_US_RESTORE, CLK 10 MHz, macro defined)
REQ-029 EXT_RST_N=0, then FF_US_RESTORE=0, SS_BUSY=0 -> FABRIC_RESET_N=0 with no clock edge; EXT_RST_N=1 -> FABRIC_RESET_N=1 after 3rd rising edge, 0 before.
REQ-030 PLL_LOCK=0 -> FABRIC_RESET_N=0 immediately; PLL_LOCK=1 -> 1 after 3 edges; undefined macro -> PLL_LOCK=0 leaves FABRIC_RESET_N=1.
REQ-031 INIT_DONE=0 -> FABRIC_RESET_N=0; INIT_DONE=1 -> 1 after 3 edges.
REQ-032 Release with SS_BUSY=1 held 10 edges -> FABRIC_RESET_N stays 0; SS_BUSY=0 -> 1 after 3 further edges; later SS_BUSY=1 -> stays 1.
REQ-033 PLL_POWERDOWN_B: BANK_y=0,POR_N=0 -> 0; BANK_y=1,POR_N=0 -> 0; POR_N=1 -> 1; BANK_y=0 -> 0; each within 1 ns, no clock.
REQ-034 EXT_RST_N pulsed low after 2 of 3 release edges -> FABRIC_RESET_N stays 0, full 3 edges required after release.
